// File: rtl/seq_detector_param.sv
`default_nettype none
// ============================================================================
// Module   : seq_detector_param
// Brief    : Programmable serial pattern detector (1..PAT_W bits, overlapping
//            or restart-after-match) with registered match pulse and
//            saturating match counter.
// Revision : 1.0 - initial release
// ============================================================================
module seq_detector_param #(
    parameter int               PAT_W   = 4,
    parameter int               CNT_W   = 8,
    parameter logic [PAT_W-1:0] PAT_DEF = 4'b1101,
    parameter int               LEN_W   = $clog2(PAT_W + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             x_in,
    input  logic             x_valid,
    input  logic             cfg_load,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             cfg_overlap,
    input  logic             cnt_clr,
    output logic             match,
    output logic [CNT_W-1:0] match_cnt,
    output logic             cnt_sat
);

    localparam logic [LEN_W-1:0] c_LEN_MAX = LEN_W'(PAT_W);
    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

    logic [PAT_W-1:0] r_pattern;
    logic [LEN_W-1:0] r_len;
    logic             r_overlap;
    logic [PAT_W-1:0] r_hist;
    logic [LEN_W-1:0] r_fill;
    logic             r_match;
    logic [CNT_W-1:0] r_cnt;
    logic             r_sat;

    logic [PAT_W-1:0] w_new_hist;
    logic [PAT_W-1:0] w_mask;
    logic [LEN_W-1:0] w_fill_inc;
    logic [LEN_W-1:0] w_cfg_len;
    logic             w_full;
    logic             w_hit;
    logic             w_hit_acc;

    assign w_new_hist = {r_hist[PAT_W-2:0], x_in};
    assign w_fill_inc = (r_fill == c_LEN_MAX) ? r_fill : r_fill + LEN_W'(1);
    assign w_full     = ({1'b0, r_fill} + (LEN_W + 1)'(1)) >= {1'b0, r_len};

    // Only the low r_len bits of history and pattern take part in the compare.
    always_comb begin
        w_mask = '0;
        for (int i = 0; i < PAT_W; i++) begin
            w_mask[i] = (LEN_W'(i) < r_len);
        end
    end

    assign w_hit     = w_full && ((w_new_hist & w_mask) == (r_pattern & w_mask));
    assign w_hit_acc = x_valid && !cfg_load && w_hit;

    always_comb begin
        w_cfg_len = cfg_len;
        if (cfg_len == '0) begin
            w_cfg_len = LEN_W'(1);
        end else if (cfg_len > c_LEN_MAX) begin
            w_cfg_len = c_LEN_MAX;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pattern <= PAT_DEF;
            r_len     <= c_LEN_MAX;
            r_overlap <= 1'b1;
            r_hist    <= '0;
            r_fill    <= '0;
            r_match   <= 1'b0;
        end else begin
            r_match <= 1'b0;
            if (cfg_load) begin
                r_pattern <= cfg_pattern;
                r_len     <= w_cfg_len;
                r_overlap <= cfg_overlap;
                r_hist    <= '0;
                r_fill    <= '0;
            end else if (x_valid) begin
                r_hist  <= w_new_hist;
                r_match <= w_hit;
                // Restart mode discards everything seen so far after a hit.
                r_fill  <= (w_hit && !r_overlap) ? '0 : w_fill_inc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            r_cnt <= '0;
            r_sat <= 1'b0;
        end else if (w_hit_acc && (r_cnt != c_CNT_MAX)) begin
            r_cnt <= r_cnt + CNT_W'(1);
            if (r_cnt == c_CNT_MAX - CNT_W'(1)) begin
                r_sat <= 1'b1;
            end
        end
    end

    assign match     = r_match;
    assign match_cnt = r_cnt;
    assign cnt_sat   = r_sat;

endmodule
`default_nettype wire
